// File: rtl/rx_word_packer.sv
// GMII receive front end: strips preamble/SFD, packs frame bytes big-endian into 32-bit words with sof/eof framing.
// Latency: a word leaves 5 cycles after its last byte; the final word leaves 1 or 2 cycles after rxdv falls.
// No backpressure: the PHY byte stream cannot be stalled, so output words are pulses that must be taken when presented.
module rx_word_packer #(
    parameter int MAXWORDS = 380,
    parameter int MAXPRE   = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rxdv,
    input  logic        rxer,
    input  logic [7:0]  rxd,
    output logic        validout,
    output logic        sof,
    output logic        eof,
    output logic [31:0] dataout,
    output logic [2:0]  lastbytes,
    output logic        frameerror,
    output logic [15:0] framecount
);
    localparam int PW = $clog2(MAXPRE + 1);
    localparam int WW = $clog2(MAXWORDS + 1);
    localparam int BW = $clog2(4 * MAXWORDS + 5);

    typedef enum logic [2:0] {DROP, IDLE, PREAMBLE, DATA, FLUSH} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] precount, precount_nxt;
    logic [BW-1:0] bytecount, bytecount_nxt;
    logic [WW-1:0] wordcount, wordcount_nxt;
    logic [31:0]   pack, pack_nxt;
    logic [31:0]   hold, hold_nxt;
    logic          hold_vld, hold_vld_nxt;
    logic          first, first_nxt;
    logic          errflag, errflag_nxt;
    logic          valid_nxt, sof_nxt, eof_nxt, fe_nxt;
    logic [31:0]   data_nxt;
    logic [2:0]    lb_nxt;
    logic [15:0]   fc_nxt;
    logic [1:0]    lane;
    logic [31:0]   merged;
    logic          bad;

    always_comb begin
        state_nxt     = state;
        precount_nxt  = precount;
        bytecount_nxt = bytecount;
        wordcount_nxt = wordcount;
        pack_nxt      = pack;
        hold_nxt      = hold;
        hold_vld_nxt  = hold_vld;
        first_nxt     = first;
        errflag_nxt   = errflag;
        valid_nxt     = 1'b0;
        sof_nxt       = 1'b0;
        eof_nxt       = 1'b0;
        fe_nxt        = 1'b0;
        data_nxt      = '0;
        lb_nxt        = '0;
        fc_nxt        = framecount;
        lane          = bytecount[1:0];
        merged        = pack;
        // lane 0 lands in [31:24]
        merged[{~lane, 3'b000} +: 8] = rxd;
        bad           = errflag | (bytecount < BW'(64));

        case (state)
            DROP: begin
                if (!rxdv) state_nxt = IDLE;
            end
            IDLE: begin
                if (rxdv) begin
                    if (rxd == 8'h55) begin
                        state_nxt    = PREAMBLE;
                        precount_nxt = PW'(1);
                    end else begin
                        state_nxt = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!rxdv) begin
                    state_nxt = IDLE;
                end else if (rxd == 8'h55) begin
                    if (precount >= PW'(MAXPRE)) state_nxt = DROP;
                    else                         precount_nxt = precount + 1'b1;
                end else if (rxd == 8'hD5) begin
                    state_nxt     = DATA;
                    bytecount_nxt = '0;
                    wordcount_nxt = '0;
                    errflag_nxt   = 1'b0;
                    first_nxt     = 1'b1;
                    pack_nxt      = '0;
                    hold_vld_nxt  = 1'b0;
                end else begin
                    state_nxt = DROP;
                end
            end
            DATA: begin
                if (rxdv) begin
                    errflag_nxt   = errflag | rxer;
                    bytecount_nxt = bytecount + 1'b1;
                    if (lane == 2'd3) begin
                        pack_nxt = '0;
                        if (wordcount == WW'(MAXWORDS)) begin
                            // Frame too long: close it on the held word and discard the rest.
                            valid_nxt    = 1'b1;
                            sof_nxt      = first;
                            eof_nxt      = 1'b1;
                            fe_nxt       = 1'b1;
                            lb_nxt       = 3'd4;
                            data_nxt     = hold;
                            first_nxt    = 1'b0;
                            hold_vld_nxt = 1'b0;
                            state_nxt    = DROP;
                        end else begin
                            wordcount_nxt = wordcount + 1'b1;
                            if (hold_vld) begin
                                valid_nxt = 1'b1;
                                sof_nxt   = first;
                                data_nxt  = hold;
                                first_nxt = 1'b0;
                            end
                            hold_nxt     = merged;
                            hold_vld_nxt = 1'b1;
                        end
                    end else begin
                        pack_nxt = merged;
                    end
                end else if (lane == 2'd0) begin
                    if (hold_vld) begin
                        valid_nxt = 1'b1;
                        sof_nxt   = first;
                        eof_nxt   = 1'b1;
                        fe_nxt    = bad;
                        lb_nxt    = 3'd4;
                        data_nxt  = hold;
                        if (!bad) fc_nxt = framecount + 1'b1;
                    end
                    first_nxt    = 1'b0;
                    hold_vld_nxt = 1'b0;
                    state_nxt    = IDLE;
                end else begin
                    // Partial tail: release the held word now, the padded tail next cycle.
                    if (hold_vld) begin
                        valid_nxt = 1'b1;
                        sof_nxt   = first;
                        data_nxt  = hold;
                        first_nxt = 1'b0;
                    end
                    hold_vld_nxt = 1'b0;
                    state_nxt    = FLUSH;
                end
            end
            FLUSH: begin
                valid_nxt = 1'b1;
                sof_nxt   = first;
                eof_nxt   = 1'b1;
                fe_nxt    = bad;
                lb_nxt    = {1'b0, lane};
                data_nxt  = pack;
                first_nxt = 1'b0;
                if (!bad) fc_nxt = framecount + 1'b1;
                state_nxt = rxdv ? DROP : IDLE;
            end
            default: state_nxt = DROP;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= DROP;
            precount   <= '0;
            bytecount  <= '0;
            wordcount  <= '0;
            pack       <= '0;
            hold       <= '0;
            hold_vld   <= 1'b0;
            first      <= 1'b0;
            errflag    <= 1'b0;
            validout   <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            frameerror <= 1'b0;
            dataout    <= '0;
            lastbytes  <= '0;
            framecount <= '0;
        end else begin
            state      <= state_nxt;
            precount   <= precount_nxt;
            bytecount  <= bytecount_nxt;
            wordcount  <= wordcount_nxt;
            pack       <= pack_nxt;
            hold       <= hold_nxt;
            hold_vld   <= hold_vld_nxt;
            first      <= first_nxt;
            errflag    <= errflag_nxt;
            validout   <= valid_nxt;
            sof        <= sof_nxt;
            eof        <= eof_nxt;
            frameerror <= fe_nxt;
            dataout    <= data_nxt;
            lastbytes  <= lb_nxt;
            framecount <= fc_nxt;
        end
    end
endmodule

// File: tb/tb_rx_word_packer.sv
// Bench for rx_word_packer: directed and random frames scored against a frame-level model of the packer.
module tb_rx_word_packer;
    localparam int MAXWORDS = 380;
    localparam int MAXPRE   = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        rxdv, rxer;
    logic [7:0]  rxd;
    logic        validout, sof, eof, frameerror;
    logic [31:0] dataout;
    logic [2:0]  lastbytes;
    logic [15:0] framecount;

    rx_word_packer #(.MAXWORDS(MAXWORDS), .MAXPRE(MAXPRE)) dut (
        .clock(clock), .reset(reset), .rxdv(rxdv), .rxer(rxer), .rxd(rxd),
        .validout(validout), .sof(sof), .eof(eof), .dataout(dataout),
        .lastbytes(lastbytes), .frameerror(frameerror), .framecount(framecount)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic        e;
        logic [2:0]  lb;
        logic        fe;
    } exp_t;

    exp_t        expq[$];
    int          eofq[$];
    exp_t        mx;
    int          nvec = 0;
    int          nbad = 0;
    logic [15:0] mfc  = '0;
    logic [7:0]  fb[$];
    int          err_idx = -1;
    bit          last_partial = 1'b0;
    int          last_gap = 10;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, want, cyc);
        end
    endtask

    // Frame-level reference: words are 4-byte slices of the payload, tail zero padded.
    task automatic model_frame();
        int   len;
        bit   ovf;
        bit   err;
        int   nw;
        exp_t x;
        len = fb.size();
        if (len == 0) return;
        ovf = (len >= 4 * (MAXWORDS + 1));
        nw  = ovf ? MAXWORDS : (len + 3) / 4;
        err = ovf || (len < 64) || (err_idx >= 0 && err_idx < len);
        for (int w = 0; w < nw; w++) begin
            x.d = '0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < len) x.d[31 - 8 * k -: 8] = fb[4 * w + k];
            x.s  = (w == 0);
            x.e  = (w == nw - 1);
            x.lb = !x.e ? 3'd0 : (ovf || len % 4 == 0) ? 3'd4 : 3'(len % 4);
            x.fe = x.e && err;
            expq.push_back(x);
        end
    endtask

    task automatic drive(input logic dv, input logic [7:0] b, input logic er);
        @(negedge clock);
        rxdv = dv;
        rxd  = b;
        rxer = er;
    endtask

    task automatic fill_ramp(input int len, input logic [7:0] base);
        fb.delete();
        for (int i = 0; i < len; i++) fb.push_back(base + 8'(i));
    endtask

    task automatic fill_rand(input int len);
        fb.delete();
        for (int i = 0; i < len; i++) fb.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send_frame(input int npre, input bit badsfd, input int gap);
        bit valid;
        int len;
        int e;
        len   = fb.size();
        valid = !(last_partial && last_gap == 1) && npre >= 1 && npre <= MAXPRE && !badsfd;
        if (valid) model_frame();
        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, badsfd ? 8'h12 : 8'hD5, 1'b0);
        for (int i = 0; i < len; i++) begin
            drive(1'b1, fb[i], i == err_idx);
            if (valid && i == 4 * MAXWORDS + 3) eofq.push_back(cyc + 1);
        end
        drive(1'b0, 8'h00, 1'b0);
        e = cyc + 1;
        if (valid && len > 0 && len < 4 * (MAXWORDS + 1))
            eofq.push_back((len % 4 == 0) ? e : e + 1);
        for (int g = 1; g < gap; g++) drive(1'b0, 8'h00, 1'b0);
        last_partial = valid && len > 0 && len < 4 * (MAXWORDS + 1) && (len % 4 != 0);
        last_gap     = gap;
    endtask

    always @(negedge clock) begin
        if (validout) begin
            if (expq.size() == 0) begin
                check("spurious_word", 32'(validout), 32'd0);
            end else begin
                mx = expq.pop_front();
                check("dataout", dataout, mx.d);
                check("sof", 32'(sof), 32'(mx.s));
                check("eof", 32'(eof), 32'(mx.e));
                check("lastbytes", 32'(lastbytes), 32'(mx.lb));
                check("frameerror", 32'(frameerror), 32'(mx.fe));
                if (mx.e) begin
                    if (!mx.fe) mfc = mfc + 16'd1;
                    check("framecount", 32'(framecount), 32'(mfc));
                    if (eofq.size() != 0) check("eof_cycle", cyc, eofq.pop_front());
                    else                  check("eof_cycle", cyc, 32'hFFFF_FFFF);
                end
            end
        end else begin
            check("flags_without_valid", {26'd0, sof, eof, lastbytes, frameerror}, 32'd0);
        end
    end

    initial begin
        int len, npre, gap, r;
        bit bs;
        reset = 1'b0;
        rxdv  = 1'b0;
        rxer  = 1'b0;
        rxd   = 8'h00;
        repeat (3) @(negedge clock);
        #1;
        check("rst_validout", 32'(validout), 32'd0);
        check("rst_dataout", dataout, 32'd0);
        check("rst_lastbytes", 32'(lastbytes), 32'd0);
        check("rst_framecount", 32'(framecount), 32'd0);
        @(negedge clock);
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);

        // 64, 66 and 2 byte frames, then rxer on byte 50 of 100
        err_idx = -1;
        fill_ramp(64, 8'h00); send_frame(7, 1'b0, 6);
        fill_ramp(66, 8'h00); send_frame(7, 1'b0, 6);
        fb.delete(); fb.push_back(8'hAA); fb.push_back(8'hBB); send_frame(7, 1'b0, 6);
        fill_rand(100); err_idx = 49; send_frame(7, 1'b0, 6);
        err_idx = -1;

        // bad starts, empty frame, IFG violation after a partial tail, overflow
        fill_rand(40); send_frame(1, 1'b1, 4);
        fill_ramp(64, 8'h10); send_frame(16, 1'b0, 4);
        fill_ramp(64, 8'h20); send_frame(15, 1'b0, 4);
        fb.delete(); send_frame(7, 1'b0, 4);
        fill_rand(67); send_frame(7, 1'b0, 1);
        fill_ramp(64, 8'h30); send_frame(7, 1'b0, 4);
        fill_ramp(68, 8'h40); send_frame(7, 1'b0, 4);
        fill_rand(1530); send_frame(7, 1'b0, 4);

        for (int f = 0; f < 30; f++) begin
            r   = $urandom_range(0, 9);
            len = (r < 2) ? $urandom_range(0, 8) : (r < 4) ? $urandom_range(56, 70) : $urandom_range(9, 200);
            npre = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 17) : $urandom_range(1, 15);
            bs   = ($urandom_range(0, 11) == 0);
            gap  = $urandom_range(1, 5);
            fill_rand(len);
            err_idx = (len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            send_frame(npre, bs, gap);
        end
        err_idx = -1;
        repeat (3) drive(1'b0, 8'h00, 1'b0);

        // reset in the middle of a frame, released while rxdv is still high
        fill_ramp(60, 8'h80);
        for (int w = 0; w < 4; w++) begin
            mx.d  = {fb[4 * w], fb[4 * w + 1], fb[4 * w + 2], fb[4 * w + 3]};
            mx.s  = (w == 0);
            mx.e  = 1'b0;
            mx.lb = 3'd0;
            mx.fe = 1'b0;
            expq.push_back(mx);
        end
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, fb[i], 1'b0);
        @(negedge clock);
        rxd = fb[20];
        #2 reset = 1'b0;
        mfc = '0;
        #1;
        check("midrst_validout", 32'(validout), 32'd0);
        check("midrst_dataout", dataout, 32'd0);
        check("midrst_framecount", 32'(framecount), 32'd0);
        for (int i = 21; i < 60; i++) begin
            drive(1'b1, fb[i], 1'b0);
            if (i == 24) #2 reset = 1'b1;
        end
        repeat (4) drive(1'b0, 8'h00, 1'b0);
        last_partial = 1'b0;
        last_gap     = 4;
        fill_ramp(64, 8'h00); send_frame(7, 1'b0, 6);
        check("framecount_after_reset", 32'(framecount), 32'd1);

        repeat (10) @(negedge clock);
        check("words_outstanding", expq.size(), 32'd0);
        check("eofs_outstanding", eofq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/rx_word_packer.md
# rx_word_packer

Receive front end: accepts the 8-bit GMII-style byte stream from the PHY, strips preamble and SFD, and packs frame bytes big-endian into 32-bit words. Delivers them with valid/sof/eof framing to the header clipper's `validin`/`sof`/`eof`/`datain` inputs. Also reports trailing-byte count, per-frame errors and a good-frame count.

## Interface
- `MAXWORDS`, 380: maximum words per frame (1518 bytes incl. FCS, rounded up); exceeding it is an overflow error.
- `MAXPRE`, 15: maximum accepted 0x55 preamble bytes before SFD.

Ports:
- `clock`  in  1  system clock, one byte per cycle when `rxdv`=1.
- `reset`  in  1  asynchronous, active-low reset.
- `rxdv`  in  1  receive data valid from PHY.
- `rxer`  in  1  receive error from PHY.
- `rxd`  in  8  receive byte.
- `validout`  out  1  `dataout` holds a frame word this cycle.
- `sof`  out  1  first word of frame; only with `validout`.
- `eof`  out  1  last word of frame; only with `validout`.
- `dataout`  out  32  frame word; first byte in [31:24]; unused trailing bytes zero.
- `lastbytes`  out  3  valid bytes in the eof word (1..4); 0 when `eof`=0.
- `frameerror`  out  1  frame bad (rxer, runt <64 bytes, overflow); only with `eof`.
- `framecount`  out  16  count of frames ended with `eof`=1 and `frameerror`=0; wraps 0xFFFF->0.

## Operation
- States: `DROP`, `IDLE`, `PREAMBLE`, `DATA`, `FLUSH`.
- Reset: all outputs 0, `framecount`=0, shift/hold registers cleared, state=`DROP`.
- DROP: no output; `rxdv`=0 -> `IDLE`.
- IDLE: `rxdv`=1 & `rxd`=0x55 -> `PREAMBLE` (precount=1); `rxdv`=1 & other byte -> `DROP`.
- PREAMBLE:
  - 0x55 -> precount++; precount would exceed `MAXPRE` -> `DROP`.
  - 0xD5 -> `DATA`; clear bytecount, wordcount, errflag, first flag.
  - Other byte -> `DROP`.
  - `rxdv`=0 -> `IDLE`.
- DATA, each `rxdv`=1 byte:
  - Shift byte into the packing register at lane `bytecount[1:0]` (lane 0 = [31:24]).
  - `rxer`=1 sets errflag.
  - 4th byte completes a word: if hold register is full, emit the held word (`validout`=1, `sof` if first word of frame, `eof`=0). The new word then enters the hold register.
- The one-word hold lets `eof` mark the true last word.
- DATA, `rxdv`=0, partial bytes = 0: emit held word with `eof`=1, `lastbytes`=4 -> `IDLE`.
- DATA, `rxdv`=0, partial bytes n > 0:
  - This cycle: emit held word (if any) with `eof`=0 -> `FLUSH`.
  - `FLUSH` cycle: emit zero-padded partial word, `eof`=1, `lastbytes`=n -> `IDLE`.
  - If no held word exists (frame < 4 bytes), go straight to `FLUSH`.
- Zero data bytes after SFD: nothing emitted, `framecount` unchanged.
- Error resolution at `eof`: `frameerror` = errflag | (total bytes < 64) | overflow.
- Overflow: a completed word that would make wordcount > `MAXWORDS` is discarded. The held word is emitted with `eof`=1, `frameerror`=1, `lastbytes`=4 -> `DROP`.
- `sof` and `eof` may both be 1 on a single-word frame.
- `framecount` increments in the cycle `eof`=1 and `frameerror`=0.

## Timing
- Outputs are registered; `validout`/`sof`/`eof`/`lastbytes`/`frameerror` are single-cycle pulses.
- Word k is output in the cycle after the edge that samples the 4th byte of word k+1. Latency: 5 cycles from its own last byte.
- Last word follows `rxdv` fall:
  - 1 cycle after the edge that samples `rxdv`=0 when bytes%4=0.
  - Otherwise 2 cycles, the held word appearing 1 cycle earlier.
- `validout` is high at most once per 4 cycles, except the back-to-back held/partial pair at frame end.
- `rxdv` rising again during `FLUSH` (IFG violation): byte ignored, state -> `DROP` after flush completes.
- Async reset mid-frame: outputs clear immediately, no `eof` is generated. After release, state is `DROP`, so the frame in progress is discarded until `rxdv` goes low.

## Test plan
- 7×0x55, 0xD5, 64 bytes 0x00..0x3F, `rxdv` low:
  - 16 words; first word 0x00010203 with `sof`.
  - Last word 0x3C3D3E3F with `eof`, `lastbytes`=4, `frameerror`=0.
  - `framecount` 0->1.
- Same frame with 66 bytes: word 16 emitted without `eof`, then next cycle 0x40410000 with `eof`, `lastbytes`=2, no error.
- 2-byte frame 0xAA,0xBB: single word 0xAABB0000, `sof`=`eof`=1, `lastbytes`=2, `frameerror`=1 (runt), `framecount` unchanged.
- 100-byte frame with `rxer`=1 on byte 50: all 25 words emitted, last has `eof`, `frameerror`=1.
- Bad start: preamble 0x55, 0x12, …: no `validout` until next valid frame. Also 16×0x55 then 0xD5 -> dropped.
- Async reset asserted after 20 data bytes, released with `rxdv` still high: outputs 0 at once, no words until `rxdv` low. Next clean 64-byte frame accepted normally; `framecount`=1.
